// File: rtl/regincr_pipe.sv
// regincr_pipe: NSTAGES-deep register-incrementer pipeline with val/rdy
// handshakes on both ends.
//
// Each stage registers its upstream value and adds INCR. The addition wraps
// modulo 2^WIDTH, or clamps at 2^WIDTH-1 when SATURATE=1. The pipe supports
// full backpressure and collapses bubbles. It also keeps a registered count
// of the entries in flight.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high; discards all in-flight data
//   in_      input data (WIDTH)
//   in_val   in_ holds a valid transaction
//   in_rdy   pipe accepts this cycle (combinational from out_rdy)
//   out      last-stage data (WIDTH)
//   out_val  out holds a valid result
//   out_rdy  consumer accepts this cycle
//   count    number of valid entries in flight (0..NSTAGES)
module regincr_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NSTAGES  = 3,
  parameter int unsigned INCR     = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               in_,
  input  logic                           in_val,
  output logic                           in_rdy,
  output logic [WIDTH-1:0]               out,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [$clog2(NSTAGES+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(NSTAGES + 1);
  localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

  logic [WIDTH-1:0] data_q [NSTAGES];
  logic [WIDTH-1:0] data_d [NSTAGES];
  logic [NSTAGES-1:0] val_q, val_d;
  logic [CW-1:0] count_q, count_d;

  // adv[k] is the go signal for stage k.
  // adv[NSTAGES] stands in for the consumer, so the backward chain has a
  // uniform form at every stage.
  logic [NSTAGES:0] adv;
  logic in_xfer, out_xfer;

  function automatic logic [WIDTH-1:0] incr_f(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] sum;
    sum = {1'b0, x} + {1'b0, INCR_W};
    if (SATURATE && sum[WIDTH])
      return '1;
    else
      return sum[WIDTH-1:0];
  endfunction

  always_comb begin
    adv = '0;
    adv[NSTAGES] = out_rdy;
    for (int unsigned j = 0; j < NSTAGES; j++) begin
      adv[NSTAGES-1-j] = !val_q[NSTAGES-1-j] | adv[NSTAGES-j];
    end

    in_xfer  = in_val & adv[0];
    out_xfer = val_q[NSTAGES-1] & out_rdy;

    data_d = data_q;
    val_d  = val_q;
    if (adv[0]) begin
      data_d[0] = incr_f(in_);
      val_d[0]  = in_val;
    end
    for (int unsigned k = 1; k < NSTAGES; k++) begin
      if (adv[k]) begin
        data_d[k] = incr_f(data_q[k-1]);
        val_d[k]  = val_q[k-1];
      end
    end

    count_d = count_q;
    case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '{default: '0};
      val_q   <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      val_q   <= val_d;
      count_q <= count_d;
    end
  end

  assign in_rdy  = adv[0];
  assign out     = data_q[NSTAGES-1];
  assign out_val = val_q[NSTAGES-1];
  assign count   = count_q;

endmodule

// File: tb/tb_regincr_pipe.sv
module tb_regincr_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_;
  logic       in_val;
  logic       out_rdy;

  logic       in_rdy, out_val;
  logic [7:0] out;
  logic [1:0] count;

  logic       s_in_rdy, s_out_val;
  logic [7:0] s_out;
  logic [1:0] s_count;

  logic       o_in_rdy, o_out_val;
  logic [7:0] o_out;
  logic [0:0] o_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regincr_pipe #(.WIDTH(8), .NSTAGES(3), .INCR(1), .SATURATE(1'b0)) dut (
    .clk(clk), .reset(reset), .in_(in_), .in_val(in_val), .in_rdy(in_rdy),
    .out(out), .out_val(out_val), .out_rdy(out_rdy), .count(count)
  );

  regincr_pipe #(.WIDTH(8), .NSTAGES(3), .INCR(8'h40), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .in_(in_), .in_val(in_val), .in_rdy(s_in_rdy),
    .out(s_out), .out_val(s_out_val), .out_rdy(out_rdy), .count(s_count)
  );

  regincr_pipe #(.WIDTH(8), .NSTAGES(1), .INCR(0), .SATURATE(1'b0)) dut_one (
    .clk(clk), .reset(reset), .in_(in_), .in_val(in_val), .in_rdy(o_in_rdy),
    .out(o_out), .out_val(o_out_val), .out_rdy(out_rdy), .count(o_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams three back-to-back items with out_rdy=1 through all three pipes.
  task automatic stream3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    out_rdy = 1'b1; in_val = 1'b1; in_ = a;
    tick();
    check("one_out_a", {o_out_val, o_out}, {1'b1, a});
    in_ = b;
    tick();
    check("one_out_b", {o_out_val, o_out}, {1'b1, b});
    check("wrap_not_yet", out_val, 1'b0);
    in_ = c;
    tick();
    in_val = 1'b0;
    check("one_out_c", {o_out_val, o_out}, {1'b1, c});
    check("wrap_out0", {out_val, out}, {1'b1, w0});
    check("sat_out0", {s_out_val, s_out}, {1'b1, s0});
    check("count_peak", count, 2'd3);
    tick();
    check("wrap_out1", {out_val, out}, {1'b1, w1});
    check("sat_out1", {s_out_val, s_out}, {1'b1, s1});
    check("count_drain2", count, 2'd2);
    tick();
    check("wrap_out2", {out_val, out}, {1'b1, w2});
    check("sat_out2", {s_out_val, s_out}, {1'b1, s2});
    check("count_drain1", count, 2'd1);
    tick();
    check("wrap_empty", out_val, 1'b0);
    check("count_empty", count, 2'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_item;
    logic       hold;
    logic [7:0] held;
    int         pushed;
    int         cycles;

    reset = 1'b1; in_ = '0; in_val = 1'b0; out_rdy = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    check("rst_out", out, 8'h00);
    check("rst_out_val", out_val, 1'b0);
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_count", count, 2'd0);
    check("rst_sat_out_val", s_out_val, 1'b0);
    reset = 1'b0;

    // Wrapping stream and saturating stream, run in parallel.
    stream3(8'h05, 8'h10, 8'hFE, 8'h08, 8'h13, 8'h01, 8'hC5, 8'hD0, 8'hFF);
    stream3(8'h10, 8'h90, 8'hFF, 8'h13, 8'h93, 8'h02, 8'hD0, 8'hFF, 8'hFF);

    // Backpressure until the pipe is full, then release.
    out_rdy = 1'b0; in_val = 1'b1;
    in_ = 8'h01;
    #1 check("bp_rdy_empty", in_rdy, 1'b1);
    tick(); in_ = 8'h02;
    tick(); in_ = 8'h03;
    tick(); in_ = 8'h04;
    #1;
    check("bp_full_in_rdy", in_rdy, 1'b0);
    check("bp_full_count", count, 2'd3);
    check("bp_full_out", {out_val, out}, {1'b1, 8'h04});
    tick();
    check("bp_hold_out", {out_val, out}, {1'b1, 8'h04});
    check("bp_hold_count", count, 2'd3);
    tick();
    check("bp_hold_out2", {out_val, out}, {1'b1, 8'h04});
    out_rdy = 1'b1;
    #1 check("bp_release_in_rdy", in_rdy, 1'b1);
    tick();
    in_val = 1'b0;
    check("bp_out_05", {out_val, out}, {1'b1, 8'h05});
    check("bp_count_both", count, 2'd3);
    tick();
    check("bp_out_06", {out_val, out}, {1'b1, 8'h06});
    tick();
    check("bp_out_07", {out_val, out}, {1'b1, 8'h07});
    check("bp_count_1", count, 2'd1);
    tick();
    check("bp_drained", out_val, 1'b0);

    // Random bubbles and stalls against an in-order queue model.
    pushed = 0; cycles = 0; hold = 1'b0; held = '0;
    while (pushed < 1000 && cycles < 20000) begin
      check("rnd_count", {30'd0, count}, q.size());
      if (hold) check("rnd_stable", {out_val, out}, {1'b1, held});
      in_val  = ($urandom_range(0, 3) != 0);
      in_     = 8'($urandom);
      out_rdy = ($urandom_range(0, 2) != 0);
      #1;
      if (out_val && out_rdy) begin
        if (q.size() == 0) check("rnd_unexpected_out", 1'b1, 1'b0);
        else begin
          exp_item = q.pop_front();
          check("rnd_out", out, exp_item);
        end
      end
      if (in_val && in_rdy) begin
        q.push_back(in_ + 8'd3);
        pushed++;
      end
      hold = out_val && !out_rdy;
      held = out;
      tick();
      cycles++;
    end
    check("rnd_all_pushed", pushed, 1000);
    in_val = 1'b0; out_rdy = 1'b1; cycles = 0;
    while (q.size() != 0 && cycles < 20) begin
      #1;
      if (out_val) begin
        exp_item = q.pop_front();
        check("drain_out", out, exp_item);
      end
      tick();
      cycles++;
    end
    check("drain_empty", q.size(), 0);
    check("drain_count", count, 2'd0);

    // Reset with two items in flight and the consumer stalled.
    out_rdy = 1'b0; in_val = 1'b1; in_ = 8'hAA;
    tick(); in_ = 8'hBB;
    tick(); in_val = 1'b0;
    check("mid_count_2", count, 2'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_out_val", out_val, 1'b0);
    check("mid_count", count, 2'd0);
    check("mid_in_rdy", in_rdy, 1'b1);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_ghost", out_val, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regincr_pipe.md
Name: regincr_pipe

Overview:
- Parametrised successor to the single-stage register-incrementer.
- NSTAGES-deep pipeline; each stage registers its upstream value and adds INCR (wrapping, or saturating when SATURATE=1).
- Input and output use val/rdy handshakes with full backpressure, bubble tolerance and an occupancy count.
- Used as a latency-configurable arithmetic pipe and as a reference pipeline for handshake verification.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- NSTAGES, 3, number of pipeline stages (>=1).
- INCR, 1, per-stage increment; unsigned, WIDTH bits, 0 legal.
- SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp at 2^WIDTH-1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_  input  WIDTH  input data.
- in_val  input  1  in_ holds a valid transaction.
- in_rdy  output  1  pipe can accept this cycle.
- out  output  WIDTH  result data (last stage register).
- out_val  output  1  out holds a valid result.
- out_rdy  input  1  consumer accepts this cycle.
- count  output  clog2(NSTAGES+1)  number of valid entries in flight.

Behaviour:
- State per stage k (0..NSTAGES-1): data[k] (WIDTH bits), val[k] (1 bit).
- Reset, synchronous on the edge where reset=1:
  - All val[k]=0 and data[k]=0.
  - Outputs after that edge: out=0, out_val=0, count=0, in_rdy=1.
  - reset takes priority over any handshake in the same cycle; in-flight data is discarded.
- Transfers:
  - Input transfer: in_val & in_rdy.
  - Output transfer: out_val & out_rdy.
- Stage advance, evaluated from the last stage backwards:
  - go[N-1] = !val[N-1] | out_rdy.
  - go[k] = !val[k] | go[k+1].
  - in_rdy = go[0], combinational from out_rdy; no registered skid.
- On each edge, for every stage with go[k]=1:
  - Stage 0 captures f(in_), val[0] <= in_val.
  - Stage k>0 captures f(data[k-1]), val[k] <= val[k-1].
  - Stages with go[k]=0 hold data and val.
- f(x):
  - SATURATE=0: (x+INCR) mod 2^WIDTH.
  - SATURATE=1: min(x+INCR, 2^WIDTH-1); compute the sum in WIDTH+1 bits.
- Data capture into a stage whose incoming val is 0 is permitted (don't-care data); only val gates meaning.
- Outputs: out=data[N-1], out_val=val[N-1].
- Latency and throughput:
  - With no stall, an item accepted on edge t appears at out_val after edge t+NSTAGES-1; it is visible NSTAGES cycles after in_val is presented.
  - Throughput is 1 item/cycle.
  - End-to-end result is f applied NSTAGES times. With wrap this equals in_+NSTAGES*INCR mod 2^WIDTH.
- Ordering: strict FIFO. No drop and no duplication under any out_rdy pattern.
- Bubbles: gaps in in_val propagate as gaps. Stalled bubbles are collapsed when a downstream stage is empty.
- Full: all val=1 and out_rdy=0 -> in_rdy=0 and all state holds.
- Simultaneous input and output transfer while full is allowed (in_rdy=1 when out_rdy=1).
- count:
  - Registered.
  - +1 on input transfer only; -1 on output transfer only; unchanged when both or neither occur.
  - Range 0..NSTAGES; always equals the sum of val[k].
- out_val and out must stay stable while out_val=1 and out_rdy=0.
- NSTAGES=1: degenerates to a single registered incrementer with handshake; in_rdy = !val[0] | out_rdy.

Test Plan:
1. Reset with WIDTH=8, NSTAGES=3, INCR=1: hold reset 2 cycles -> out=0x00, out_val=0, in_rdy=1, count=0.
2. Stream with out_rdy=1: in_ 0x05, 0x10, 0xFE on consecutive cycles -> out 0x08, 0x13, 0x01 (wrap), one per cycle, first one 3 cycles after presentation; count peaks at 3.
3. SATURATE=1, INCR=0x40: in_ 0x10 -> 0xD0; in_ 0x90 -> 0xFF; in_ 0xFF -> 0xFF.
4. Backpressure: out_rdy=0, present 0x01..0x04 -> first 3 accepted, in_rdy=0 on 0x04, count=3, out=0x04 held stable. Release out_rdy -> out 0x04, 0x05, 0x06, 0x07 in order; 0x04 accepted the cycle out_rdy rises.
5. Bubbles and random stalls: random in_val/out_rdy over 1000 items -> scoreboard matches in order; count always equals the in-flight total and never exceeds 3.
6. Reset mid-operation: with 2 items in flight and out_rdy=0, assert reset for 1 cycle -> next cycle out_val=0, count=0, in_rdy=1; pre-reset items never appear at out.
